line_raster: RTL and testbench
==============================

Name: line_raster

Overview:
- Responder end of the Start/Done line-drawing handshake used by the triangle edge sequencer.
- Accepts two screen-space endpoints and walks the line with integer Bresenham stepping, one pixel per clock, on DrawX/DrawY with a plot strobe.
- Pulses draw_line_Done when the walk finishes.
- Feeds the frame-buffer write path.

Parameters:
COORD_W, 10, width of each screen coordinate
SCREEN_W, 640, horizontal pixel limit (used only with LINE_CLIP_EN)
SCREEN_H, 480, vertical pixel limit (used only with LINE_CLIP_EN)

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
draw_line_Start  input  1  request; sampled only in Idle
x0  input  COORD_W  start x, unsigned
y0  input  COORD_W  start y, unsigned
x1  input  COORD_W  end x, unsigned
y1  input  COORD_W  end y, unsigned
DrawX  output  COORD_W  current pixel x
DrawY  output  COORD_W  current pixel y
plot  output  1  DrawX/DrawY is a pixel to write this cycle
draw_line_Done  output  1  one-cycle completion pulse

Behaviour:
- Interface: one clock Clk; Reset is synchronous and active-high.
- Reset values: state Idle, DrawX=0, DrawY=0, plot=0, draw_line_Done=0, all internal registers 0.
- States: Idle, Step, Done.
- Idle:
  - plot=0, Done=0.
  - On draw_line_Start=1, latch x0/y0/x1/y1 into internal registers and go to Step.
  - Init computations are registered on the same edge:
    - cur=(x0,y0)
    - dx=|x1-x0|, dy=-|y1-y0|
    - sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1
    - err=dx+dy
- Arithmetic: err, dx, dy, e2 are signed COORD_W+2 bits; no overflow for any 10-bit endpoint pair.
- Step (one pixel per cycle):
  - DrawX/DrawY=cur and plot=1 every Step cycle.
  - If cur==(x1,y1): next state Done.
  - Otherwise let e2=2*err:
    - if e2>=dy: err+=dy, x+=sx
    - if e2<=dx: err+=dx, y+=sy
    - Both updates may apply in one cycle, using the same pre-update err.
- Done:
  - draw_line_Done=1 and plot=0 for exactly one cycle, then Idle unconditionally.
  - DrawX/DrawY hold the last pixel.
- Latency:
  - Start sampled at edge E0.
  - First pixel is visible in the cycle after E0.
  - N=max(|x1-x0|,|y1-y0|)+1 consecutive plot cycles.
  - draw_line_Done is high in cycle N+1 after E0.
- Back-to-back: Start asserted in the cycle right after Done (responder back in Idle) is accepted; zero dead cycles between lines.
- draw_line_Start while in Step or Done is ignored and not queued.
- Endpoint inputs may change after acceptance; the latched copies are used.
- Degenerate line (x0==x1, y0==y1): exactly one plot cycle, then Done.
- Reset mid-operation: next edge forces Idle, plot=0, Done=0, DrawX/DrawY=0; no Done pulse is emitted for the aborted line.
- DrawX/DrawY hold their value whenever plot=0, except after reset.

Optional Feature:
- Macro: LINE_CLIP_EN.
- Defined:
  - plot is forced 0 in any Step cycle where DrawX>=SCREEN_W or DrawY>=SCREEN_H.
  - Stepping, cycle count and Done timing are unchanged.
- Undefined:
  - No clipping; every Step cycle asserts plot=1.
  - The SCREEN_W/SCREEN_H parameters are unused.

Test Plan:
- Point (5,5)->(5,5), Start pulse -> one plot cycle at (5,5), Done in the next cycle, then Idle.
- Horizontal (0,0)->(3,0) -> plots (0,0),(1,0),(2,0),(3,0) on consecutive cycles 1-4, Done on cycle 5.
- Reverse diagonal (10,10)->(7,7) -> plots (10,10),(9,9),(8,8),(7,7), then Done.
- Steep (0,0)->(2,5) -> plots (0,0),(0,1),(1,2),(1,3),(2,4),(2,5), Done on cycle 7.
- Start held high during Step, plus Start in the cycle after Done for a second line (0,0)->(1,0):
  - First line is unaffected.
  - Second line is accepted with no gap.
  - Exactly two Done pulses.
- Reset asserted after 2 pixels of (0,0)->(9,0):
  - Next cycle plot=0, Done=0, DrawX=0.
  - No Done pulse.
  - A fresh Start works normally.
- With LINE_CLIP_EN defined, (638,0)->(641,0):
  - 4 Step cycles.
  - plot=1 only at x=638,639.
  - Done on cycle 5.

Source files
------------

// File: rtl/line_raster.sv
// rtl/line_raster.sv - Bresenham line walker, one pixel per clock, Start/Done handshake (optional LINE_CLIP_EN screen clipping)
module line_raster #(
    parameter int COORD_W  = 10,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               draw_line_Start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               plot,
    output logic               draw_line_Done
);

    // Two guard bits keep err, dx, dy and 2*err exact for any endpoint pair.
    localparam int W = COORD_W + 2;
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    // Reject nonsensical screen or coordinate sizes at elaboration.
    if (SCREEN_W < 1 || SCREEN_H < 1 || COORD_W < 2) begin : g_bad_params
        $error("line_raster: invalid parameter values");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [COORD_W-1:0]    cur_x_q, cur_x_d;
    logic [COORD_W-1:0]    cur_y_q, cur_y_d;
    logic [COORD_W-1:0]    end_x_q, end_x_d;
    logic [COORD_W-1:0]    end_y_q, end_y_d;
    logic signed [W-1:0]   dx_q, dx_d;
    logic signed [W-1:0]   dy_q, dy_d;
    logic signed [W-1:0]   err_q, err_d;
    logic                  sx_pos_q, sx_pos_d;
    logic                  sy_pos_q, sy_pos_d;

    logic signed [W-1:0]   raw_dx;
    logic signed [W-1:0]   raw_dy;
    logic signed [W-1:0]   abs_dx;
    logic signed [W-1:0]   abs_dy;
    logic signed [W-1:0]   e2;
    logic                  at_end;
    logic                  in_screen;

    // Setup terms for a new line, taken straight from the endpoint inputs.
    assign raw_dx = {2'b00, x1} - {2'b00, x0};
    assign raw_dy = {2'b00, y1} - {2'b00, y0};
    assign abs_dx = raw_dx[W-1] ? -raw_dx : raw_dx;
    assign abs_dy = raw_dy[W-1] ? -raw_dy : raw_dy;

    assign e2     = err_q <<< 1;
    assign at_end = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);

`ifdef LINE_CLIP_EN
    assign in_screen = ({{(32-COORD_W){1'b0}}, cur_x_q} < $unsigned(SCREEN_W)) &&
                       ({{(32-COORD_W){1'b0}}, cur_y_q} < $unsigned(SCREEN_H));
`else
    assign in_screen = 1'b1;
`endif

    // The walker position is the drawn pixel; it holds through Done and Idle.
    assign DrawX          = cur_x_q;
    assign DrawY          = cur_y_q;
    assign plot           = (state_q == S_STEP) && in_screen;
    assign draw_line_Done = (state_q == S_DONE);

    // Next-state: accept a line in Idle, step one pixel per cycle, pulse Done.
    always_comb begin
        state_d  = state_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        end_x_d  = end_x_q;
        end_y_d  = end_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_pos_d = sx_pos_q;
        sy_pos_d = sy_pos_q;

        unique case (state_q)
            S_IDLE: begin
                if (draw_line_Start) begin
                    cur_x_d  = x0;
                    cur_y_d  = y0;
                    end_x_d  = x1;
                    end_y_d  = y1;
                    dx_d     = abs_dx;
                    dy_d     = -abs_dy;
                    err_d    = abs_dx - abs_dy;
                    sx_pos_d = (x0 < x1);
                    sy_pos_d = (y0 < y1);
                    state_d  = S_STEP;
                end
            end
            S_STEP: begin
                if (at_end) begin
                    state_d = S_DONE;
                end else begin
                    // Both axis decisions use the error value from before this step.
                    if (e2 >= dy_q) begin
                        err_d   = err_d + dy_q;
                        cur_x_d = sx_pos_q ? cur_x_q + ONE : cur_x_q - ONE;
                    end
                    if (e2 <= dx_q) begin
                        err_d   = err_d + dx_q;
                        cur_y_d = sy_pos_q ? cur_y_q + ONE : cur_y_q - ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            end_x_q  <= '0;
            end_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_pos_q <= 1'b0;
            sy_pos_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            end_x_q  <= end_x_d;
            end_y_q  <= end_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_pos_q <= sx_pos_d;
            sy_pos_q <= sy_pos_d;
        end
    end

endmodule

// File: tb/tb_line_raster.sv
// tb/tb_line_raster.sv - directed self-checking bench for line_raster
module tb_line_raster;

    logic       Clk;
    logic       Reset;
    logic       draw_line_Start;
    logic [9:0] x0, y0, x1, y1;
    logic [9:0] DrawX, DrawY;
    logic       plot;
    logic       draw_line_Done;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;
    int done_base;

    line_raster #(.COORD_W(10), .SCREEN_W(640), .SCREEN_H(480)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .draw_line_Start(draw_line_Start),
        .x0             (x0),
        .y0             (y0),
        .x1             (x1),
        .y1             (y1),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .plot           (plot),
        .draw_line_Done (draw_line_Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count Done pulses, sampled mid-cycle.
    always @(negedge Clk) begin
        if (draw_line_Done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int ax0, input int ay0, input int ax1, input int ay1);
        x0 = 10'(ax0);
        y0 = 10'(ay0);
        x1 = 10'(ax1);
        y1 = 10'(ay1);
    endtask

    task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1);
        set_line(ax0, ay0, ax1, ay1);
        draw_line_Start = 1'b1;
        tick();
        draw_line_Start = 1'b0;
    endtask

    // Expect a plotted pixel this cycle, then advance.
    task automatic pix(input string tag, input int ex, input int ey);
        chk({tag, ".plot"}, 32'(plot), 1);
        chk({tag, ".x"}, 32'(DrawX), 32'(ex));
        chk({tag, ".y"}, 32'(DrawY), 32'(ey));
        chk({tag, ".done_low"}, 32'(draw_line_Done), 0);
        tick();
    endtask

    // Expect the Done cycle with the last pixel held, then advance.
    task automatic done_cyc(input string tag, input int ex, input int ey);
        chk({tag, ".done"}, 32'(draw_line_Done), 1);
        chk({tag, ".plot_low"}, 32'(plot), 0);
        chk({tag, ".hold_x"}, 32'(DrawX), 32'(ex));
        chk({tag, ".hold_y"}, 32'(DrawY), 32'(ey));
        tick();
    endtask

    task automatic idle_cyc(input string tag, input int ex, input int ey);
        chk({tag, ".plot"}, 32'(plot), 0);
        chk({tag, ".done"}, 32'(draw_line_Done), 0);
        chk({tag, ".x"}, 32'(DrawX), 32'(ex));
        chk({tag, ".y"}, 32'(DrawY), 32'(ey));
    endtask

    initial begin
        Reset = 1'b1;
        draw_line_Start = 1'b0;
        set_line(0, 0, 0, 0);
        tick();
        tick();
        idle_cyc("reset", 0, 0);
        Reset = 1'b0;
        tick();
        idle_cyc("post_reset", 0, 0);

        // Degenerate point
        start_line(5, 5, 5, 5);
        pix("pt0", 5, 5);
        done_cyc("pt_done", 5, 5);
        idle_cyc("pt_idle", 5, 5);

        // Horizontal
        start_line(0, 0, 3, 0);
        pix("h0", 0, 0);
        pix("h1", 1, 0);
        pix("h2", 2, 0);
        pix("h3", 3, 0);
        done_cyc("h_done", 3, 0);
        idle_cyc("h_idle", 3, 0);

        // Reverse diagonal
        start_line(10, 10, 7, 7);
        pix("rd0", 10, 10);
        pix("rd1", 9, 9);
        pix("rd2", 8, 8);
        pix("rd3", 7, 7);
        done_cyc("rd_done", 7, 7);

        // Steep
        start_line(0, 0, 2, 5);
        pix("st0", 0, 0);
        pix("st1", 0, 1);
        pix("st2", 1, 2);
        pix("st3", 1, 3);
        pix("st4", 2, 4);
        pix("st5", 2, 5);
        done_cyc("st_done", 2, 5);

        // Start held through Step/Done; endpoints changed after acceptance
        done_base = done_cnt;
        set_line(0, 0, 2, 0);
        draw_line_Start = 1'b1;
        tick();
        set_line(0, 0, 1, 0);
        pix("bb_a0", 0, 0);
        pix("bb_a1", 1, 0);
        pix("bb_a2", 2, 0);
        done_cyc("bb_a_done", 2, 0);
        idle_cyc("bb_gap", 2, 0);
        tick();
        draw_line_Start = 1'b0;
        pix("bb_b0", 0, 0);
        pix("bb_b1", 1, 0);
        done_cyc("bb_b_done", 1, 0);
        idle_cyc("bb_idle", 1, 0);
        tick();
        tick();
        chk("bb_done_pulses", 32'(done_cnt - done_base), 2);

        // Reset in the middle of a line
        start_line(0, 0, 9, 0);
        pix("rs0", 0, 0);
        pix("rs1", 1, 0);
        done_base = done_cnt;
        Reset = 1'b1;
        tick();
        idle_cyc("rs_abort", 0, 0);
        Reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("rs_no_done", 32'(done_cnt - done_base), 0);
        idle_cyc("rs_quiet", 0, 0);
        start_line(3, 1, 4, 2);
        pix("rs_new0", 3, 1);
        pix("rs_new1", 4, 2);
        done_cyc("rs_new_done", 4, 2);

`ifdef LINE_CLIP_EN
        // Clipping at the right screen edge
        start_line(638, 0, 641, 0);
        pix("clip0", 638, 0);
        pix("clip1", 639, 0);
        chk("clip2.plot", 32'(plot), 0);
        chk("clip2.x", 32'(DrawX), 640);
        chk("clip2.done", 32'(draw_line_Done), 0);
        tick();
        chk("clip3.plot", 32'(plot), 0);
        chk("clip3.x", 32'(DrawX), 641);
        chk("clip3.done", 32'(draw_line_Done), 0);
        tick();
        done_cyc("clip_done", 641, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
